// File: rtl/trash_compactor_pkg.sv
// trash_compactor_pkg: ASCII, op and width constants shared by the parser and the day-6 evaluator
package trash_compactor_pkg;
  localparam int FIELD_W = 16;
  localparam int WORD_W = 32;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] STAR = 8'h2A;
  localparam logic [7:0] PLUS = 8'h2B;
  localparam logic [7:0] DIG_0 = 8'h30;
  localparam logic [7:0] DIG_9 = 8'h39;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;
  typedef enum logic [2:0] {GAP, NUM, OPSEEN, EMIT0, EMIT1, DRAIN} state_e;
endpackage

// File: rtl/trash_compactor_bcd_field.sv
// trash_compactor_bcd_field: left-aligned BCD digit accumulator with digit count and overflow flag
module trash_compactor_bcd_field
  import trash_compactor_pkg::*;
#(
  parameter int MAX_DIGITS = FIELD_W / 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      app_i,
  input  logic [3:0]                dig_i,
  output logic [4*MAX_DIGITS-1:0]   val_o,
  output logic                      ovf_o
);
  localparam int FW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  logic [FW-1:0] val_q;
  logic [CW-1:0] cnt_q;
  logic full;
  assign full = cnt_q == CW'(MAX_DIGITS);
  assign ovf_o = app_i && full;
  assign val_o = val_q;
  // each new digit lands one nibble below the previous, starting at the top nibble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      val_q <= '0;
      cnt_q <= '0;
    end else if (app_i && !full) begin
      val_q <= val_q | ((FW'(dig_i) << (FW - 4)) >> {cnt_q, 2'b00});
      cnt_q <= cnt_q + CW'(1);
    end
endmodule

// File: rtl/trash_compactor_parser.sv
// trash_compactor_parser: ASCII record parser packing four BCD numbers and an op into two evaluator words
module trash_compactor_parser
  import trash_compactor_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int NUMS_PER_REC = 4,
  parameter int CR_IGNORE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              op_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              rec_err,
  output logic [31:0]       rec_count
);
  localparam int FW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(NUMS_PER_REC + 1);
  localparam int IW = $clog2(NUMS_PER_REC);
  localparam logic [CW-1:0] FULL = CW'(NUMS_PER_REC);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fld_q [NUMS_PER_REC];
  logic [FW-1:0] fld_d [NUMS_PER_REC];
  logic op_q, op_d, err_q, err_d;
  logic [31:0] rec_q, rec_d;
  logic tk, is_dig, is_op, app, clr, ovf;
  logic [FW-1:0] num;
  assign byte_ready = state_q != EMIT0 && state_q != EMIT1;
  assign valid_out = !byte_ready;
  assign tk = byte_valid && byte_ready && !(CR_IGNORE != 0 && byte_in == CR);
  assign is_dig = byte_in >= DIG_0 && byte_in <= DIG_9;
  assign is_op = byte_in == STAR || byte_in == PLUS;
  assign app = tk && is_dig && (state_q == NUM || (state_q == GAP && cnt_q != FULL));
  assign data_out = state_q == EMIT1 ? {fld_q[3], fld_q[2]} : state_q == EMIT0 ? {fld_q[1], fld_q[0]} : '0;
  assign op_out = op_q;
  assign rec_err = err_q;
  assign rec_count = rec_q;
  trash_compactor_bcd_field #(.MAX_DIGITS(MAX_DIGITS)) u_field (
    .clk(clk), .rst(rst), .clr_i(clr), .app_i(app), .dig_i(byte_in[3:0]), .val_o(num), .ovf_o(ovf)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= GAP;
      cnt_q <= '0;
      fld_q <= '{default: '0};
      op_q <= OP_MUL;
      err_q <= 1'b0;
      rec_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fld_q <= fld_d;
      op_q <= op_d;
      err_q <= err_d;
      rec_q <= rec_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fld_d = fld_q;
    op_d = op_q;
    rec_d = rec_q;
    err_d = 1'b0;
    clr = 1'b0;
    case (state_q)
      GAP: if (tk) begin
        if (is_dig && cnt_q != FULL) state_d = NUM;
        else if (is_op && cnt_q == FULL) begin
          op_d = byte_in == PLUS ? OP_ADD : OP_MUL;
          state_d = OPSEEN;
        end else err_d = byte_in != SPACE && !(byte_in == LF && cnt_q == '0);
      end
      NUM: if (tk) begin
        if (byte_in == SPACE) begin
          fld_d[cnt_q[IW-1:0]] = num;
          cnt_d = cnt_q + CW'(1);
          clr = 1'b1;
          state_d = GAP;
        end else err_d = !is_dig || ovf;
      end
      OPSEEN: if (tk && byte_in == LF) state_d = EMIT0;
        else err_d = tk && byte_in != SPACE;
      EMIT0: if (ready_in) state_d = EMIT1;
      EMIT1: if (ready_in) begin
        rec_d = rec_q + 32'd1;
        fld_d = '{default: '0};
        cnt_d = '0;
        state_d = GAP;
      end
      DRAIN: if (tk && byte_in == LF) state_d = GAP;
      default: state_d = GAP;
    endcase
    // a bad newline already ends its record, so only other bytes need draining
    if (err_d) begin
      state_d = byte_in == LF ? GAP : DRAIN;
      fld_d = '{default: '0};
      cnt_d = '0;
      clr = 1'b1;
    end
  end
endmodule

// File: tb/tb_trash_compactor_parser.sv
// tb_trash_compactor_parser: scoreboard bench for the day-6 record parser
module tb_trash_compactor_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic byte_valid = 1'b0;
  logic byte_ready;
  logic [31:0] data_out;
  logic op_out;
  logic valid_out;
  logic ready_in = 1'b1;
  logic rec_err;
  logic [31:0] rec_count;
  logic [32:0] sb [$];
  logic [32:0] exp_w;
  int checks = 0, errors = 0, err_seen = 0, err_exp = 0;
  logic [31:0] rec_exp = 0;

  always #5 clk = ~clk;

  trash_compactor_parser dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .data_out(data_out), .op_out(op_out), .valid_out(valid_out), .ready_in(ready_in),
    .rec_err(rec_err), .rec_count(rec_count)
  );

  always @(negedge clk) begin
    if (rec_err) err_seen++;
    if (valid_out && ready_in) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got op=%b data=%h, none expected", op_out, data_out);
      end else begin
        exp_w = sb.pop_front();
        if ({op_out, data_out} !== exp_w) begin
          errors++;
          $display("FAIL word: got op=%b data=%h want op=%b data=%h", op_out, data_out, exp_w[32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic ok;
    byte_in = b;
    byte_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 50);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !byte_ready) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words outstanding want 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_byte_ready: got %b want 1", byte_ready); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    checks++; if (op_out !== 1'b0) begin errors++; $display("FAIL reset_op_out: got %b want 0", op_out); end
    checks++; if (rec_err !== 1'b0) begin errors++; $display("FAIL reset_rec_err: got %b want 0", rec_err); end
    checks++; if (rec_count !== 32'h0) begin errors++; $display("FAIL reset_rec_count: got %0d want 0", rec_count); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    sb.push_back({1'b0, 32'h45001230});
    sb.push_back({1'b0, 32'h70006000});
    send_str("123 45 6 7 *\n");
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_word0_latency: valid_out got %b want 1", valid_out); end
    @(posedge clk);
    #1;
    checks++; if (data_out !== 32'h70006000) begin errors++; $display("FAIL basic_word1_latency: got %h want 70006000", data_out); end
    @(posedge clk);
    #1;
    checks++; if (byte_ready !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL basic_ready_return: byte_ready=%b valid_out=%b want 1 0", byte_ready, valid_out); end
    wait_idle();
    rec_exp++;
    checks++; if (rec_count !== rec_exp) begin errors++; $display("FAIL basic_rec_count: got %0d want %0d", rec_count, rec_exp); end
    checks++; if (err_seen != err_exp) begin errors++; $display("FAIL basic_rec_err: got %0d want %0d", err_seen, err_exp); end
  endtask

  task automatic test_cr();
    sb.push_back({1'b1, 32'h22001000});
    sb.push_back({1'b1, 32'h44443330});
    send_str("  1 22 333 4444 +\015\n");
    wait_idle();
    rec_exp++;
    checks++; if (rec_count !== rec_exp) begin errors++; $display("FAIL cr_rec_count: got %0d want %0d", rec_count, rec_exp); end
    checks++; if (err_seen != err_exp) begin errors++; $display("FAIL cr_rec_err: got %0d want %0d", err_seen, err_exp); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    ready_in = 1'b0;
    sb.push_back({1'b0, 32'h45001230});
    sb.push_back({1'b0, 32'h70006000});
    send_str("123 45 6 7 *\n");
    while (!valid_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || data_out !== 32'h45001230 || op_out !== 1'b0 || byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b data=%h op=%b byte_ready=%b want 1 45001230 0 0", i, valid_out, data_out, op_out, byte_ready);
      end
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (sb.size() != 1) begin errors++; $display("FAIL bp_release_word0: got %0d outstanding want 1", sb.size()); end
    @(posedge clk);
    #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_release_word1: got %0d outstanding want 0", sb.size()); end
    wait_idle();
    rec_exp++;
    checks++; if (rec_count !== rec_exp) begin errors++; $display("FAIL bp_rec_count: got %0d want %0d", rec_count, rec_exp); end
  endtask

  task automatic test_digit_overflow();
    send_str("12345 1 1 1 *\n");
    err_exp++;
    wait_idle();
    checks++; if (rec_count !== rec_exp) begin errors++; $display("FAIL ovf_rec_count: got %0d want %0d", rec_count, rec_exp); end
    checks++; if (err_seen != err_exp) begin errors++; $display("FAIL ovf_rec_err: got %0d want %0d", err_seen, err_exp); end
    sb.push_back({1'b1, 32'h80009000});
    sb.push_back({1'b1, 32'h60007000});
    send_str("9 8 7 6 +\n");
    wait_idle();
    rec_exp++;
    checks++; if (rec_count !== rec_exp) begin errors++; $display("FAIL ovf_next_rec_count: got %0d want %0d", rec_count, rec_exp); end
  endtask

  task automatic test_short_record();
    send_str("1 2 3 *\n");
    err_exp++;
    send_str("\n");
    wait_idle();
    checks++; if (rec_count !== rec_exp) begin errors++; $display("FAIL short_rec_count: got %0d want %0d", rec_count, rec_exp); end
    checks++; if (err_seen != err_exp) begin errors++; $display("FAIL short_rec_err: got %0d want %0d", err_seen, err_exp); end
  endtask

  task automatic test_lf_error();
    send_str("1 2 3 4\n");
    err_exp++;
    sb.push_back({1'b0, 32'h20001000});
    sb.push_back({1'b0, 32'h40003000});
    send_str("1 2 3 4 *\n");
    rec_exp++;
    send_str("1 2 3 4 * +\n");
    err_exp++;
    wait_idle();
    checks++; if (rec_count !== rec_exp) begin errors++; $display("FAIL lf_rec_count: got %0d want %0d", rec_count, rec_exp); end
    checks++; if (err_seen != err_exp) begin errors++; $display("FAIL lf_rec_err: got %0d want %0d", err_seen, err_exp); end
  endtask

  task automatic test_reset_emit();
    int n = 0;
    ready_in = 1'b0;
    sb.push_back({1'b0, 32'h45001230});
    sb.push_back({1'b0, 32'h70006000});
    send_str("123 45 6 7 *\n");
    while (!valid_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (data_out !== 32'h70006000) begin errors++; $display("FAIL rst_emit1: got %h want 70006000", data_out); end
    rst = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out: got %b want 0", valid_out); end
    checks++; if (rec_count !== 32'h0) begin errors++; $display("FAIL rst_rec_count: got %0d want 0", rec_count); end
    sb.delete();
    rec_exp = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back({1'b0, 32'h60005000});
    sb.push_back({1'b0, 32'h80007000});
    send_str("5 6 7 8 *\n");
    checks++; if (data_out !== 32'h60005000) begin errors++; $display("FAIL rst_first_word: got %h want 60005000", data_out); end
    wait_idle();
    rec_exp++;
    checks++; if (rec_count !== rec_exp) begin errors++; $display("FAIL rst_after_rec_count: got %0d want %0d", rec_count, rec_exp); end
    checks++; if (err_seen != err_exp) begin errors++; $display("FAIL rst_rec_err: got %0d want %0d", err_seen, err_exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cr();
    test_backpressure();
    test_digit_overflow();
    test_short_record();
    test_lf_error();
    test_reset_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
